// File: rtl/cp0_defs_pkg.sv
// cp0_defs_pkg: shared CP0 definitions for the MIPS exception path.
//   - ExcCode values written into Cause.ExcCode
//   - Status / Cause bit indices
//   - except_i flag bit indices as carried down the pipeline
//   - exception controller FSM state encoding
package cp0_defs_pkg;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // Status register bit indices
    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_EXL    = 1;
    localparam int unsigned ST_IM_LO  = 8;

    // Cause register bit indices
    localparam int unsigned CA_SW_LO  = 8;   // IP[1:0], software interrupts
    localparam int unsigned CA_HW_LO  = 10;  // IP[7:2], hardware interrupts
    localparam int unsigned CA_BD     = 31;

    // Pipeline exception flag indices (except_i)
    localparam int unsigned EF_ADEL_F = 7;
    localparam int unsigned EF_SYS    = 6;
    localparam int unsigned EF_BP     = 5;
    localparam int unsigned EF_ERET   = 4;
    localparam int unsigned EF_RI     = 3;
    localparam int unsigned EF_OV     = 2;

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } exc_state_e;

endpackage

// File: rtl/int_sync.sv
// int_sync: per-bit flip-flop synchroniser chain for asynchronous lines.
//   clk   - clock
//   rst   - synchronous active-high reset, clears every stage
//   din   - raw asynchronous inputs (WIDTH)
//   dout  - synchronised outputs, STAGES cycles behind din (WIDTH)
module int_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception controller for the 5-stage MIPS pipe.
// Detects and prioritises interrupt / AdEL / AdES / Sys / Bp / RI / Ov / ERET,
// runs a flush of FLUSH_CYCLES cycles and produces the CP0 write bundle.
//   clk, rst          - clock, synchronous active-high reset
//   hw_int_i          - raw asynchronous hardware interrupt lines
//   mem_valid_i       - MEM slot holds a real instruction
//   stall_i           - MEM stage stalled this cycle
//   mem_pc_i/mem_bd_i - PC and delay-slot flag of the MEM instruction
//   except_i          - pipeline exception flags
//   adel_i/ades_i     - data address misaligned (load / store)
//   mem_addr_i        - data address
//   status_i/cause_i  - CP0 Status / Cause
//   epc_i             - current CP0 EPC (ERET target)
//   hw_pending_o      - synchronised interrupt lines for Cause.IP
//   exc_valid_o       - one-cycle CP0 write strobe
//   exc_code_o/exc_epc_o/exc_bd_o/exc_badvaddr_o/badv_we_o - CP0 write bundle
//   eret_o            - one-cycle ERET strobe
//   flush_o/newpc_o   - pipeline flush and redirect target
module exception_ctrl
    import cp0_defs_pkg::*;
#(
    parameter int unsigned        NUM_HW_INT   = 6,
    parameter int unsigned        SYNC_STAGES  = 2,
    parameter int unsigned        FLUSH_CYCLES = 1,
    parameter int unsigned        ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  EXC_VECTOR   = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  mem_valid_i,
    input  logic                  stall_i,
    input  logic [ADDR_W-1:0]     mem_pc_i,
    input  logic                  mem_bd_i,
    input  logic [7:0]            except_i,
    input  logic                  adel_i,
    input  logic                  ades_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           status_i,
    input  logic [31:0]           cause_i,
    input  logic [ADDR_W-1:0]     epc_i,
    output logic [NUM_HW_INT-1:0] hw_pending_o,
    output logic                  exc_valid_o,
    output logic [4:0]            exc_code_o,
    output logic [ADDR_W-1:0]     exc_epc_o,
    output logic                  exc_bd_o,
    output logic [ADDR_W-1:0]     exc_badvaddr_o,
    output logic                  badv_we_o,
    output logic                  eret_o,
    output logic                  flush_o,
    output logic [ADDR_W-1:0]     newpc_o
);

    exc_state_e state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic [7:0]        ip_vec;
    logic              int_req;
    logic              exc_hit;
    logic              is_eret;
    logic [4:0]        code;
    logic              accept;
    logic [ADDR_W-1:0] epc_calc;

    // Inputs carried for completeness of the CP0 interface but not consumed here.
    logic unused_bits;
    assign unused_bits = ^{except_i[1:0], status_i[31:16], status_i[7:2], cause_i[30:0]};

    int_sync #(
        .WIDTH  (NUM_HW_INT),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (hw_int_i),
        .dout (hw_pending_o)
    );

    // IP vector: software bits from Cause, synchronised hardware lines above;
    // hardware slots beyond NUM_HW_INT stay zero.
    always_comb begin
        ip_vec = '0;
        ip_vec[1:0] = cause_i[CA_SW_LO+1:CA_SW_LO];
        for (int unsigned i = 0; i < NUM_HW_INT; i++) begin
            ip_vec[2+i] = hw_pending_o[i];
        end
    end

    assign int_req = (|(ip_vec & status_i[ST_IM_LO+7:ST_IM_LO]))
                     && !status_i[ST_EXL] && status_i[ST_IE];

    always_comb begin
        exc_hit = 1'b0;
        is_eret = 1'b0;
        code    = EXC_INT;
        if (int_req) begin
            exc_hit = 1'b1;
            code    = EXC_INT;
        end else if (except_i[EF_ADEL_F] || adel_i) begin
            exc_hit = 1'b1;
            code    = EXC_ADEL;
        end else if (ades_i) begin
            exc_hit = 1'b1;
            code    = EXC_ADES;
        end else if (except_i[EF_SYS]) begin
            exc_hit = 1'b1;
            code    = EXC_SYS;
        end else if (except_i[EF_BP]) begin
            exc_hit = 1'b1;
            code    = EXC_BP;
        end else if (except_i[EF_RI]) begin
            exc_hit = 1'b1;
            code    = EXC_RI;
        end else if (except_i[EF_OV]) begin
            exc_hit = 1'b1;
            code    = EXC_OV;
        end else if (except_i[EF_ERET]) begin
            is_eret = 1'b1;
        end
    end

    // Only an advancing, valid instruction in IDLE is accepted; anything else
    // is retaken when the instruction reaches MEM again / moves on.
    assign accept = (state == S_IDLE) && mem_valid_i && !stall_i && (exc_hit || is_eret);

    assign epc_calc = mem_bd_i ? (mem_pc_i - ADDR_W'(4)) : mem_pc_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = 2'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign flush_o = (state == S_FLUSH);

    // With EXL already set, EPC/BD are rewritten with their current values so
    // the original return point survives a nested exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_valid_o    <= 1'b0;
            exc_code_o     <= '0;
            exc_epc_o      <= '0;
            exc_bd_o       <= 1'b0;
            exc_badvaddr_o <= '0;
            badv_we_o      <= 1'b0;
            eret_o         <= 1'b0;
            newpc_o        <= '0;
        end else begin
            exc_valid_o    <= 1'b0;
            exc_code_o     <= '0;
            exc_epc_o      <= '0;
            exc_bd_o       <= 1'b0;
            exc_badvaddr_o <= '0;
            badv_we_o      <= 1'b0;
            eret_o         <= 1'b0;
            if (accept) begin
                newpc_o <= is_eret ? epc_i : EXC_VECTOR;
                if (is_eret) begin
                    eret_o <= 1'b1;
                end else begin
                    exc_valid_o <= 1'b1;
                    exc_code_o  <= code;
                    if (status_i[ST_EXL] && (code != EXC_INT)) begin
                        exc_epc_o <= epc_i;
                        exc_bd_o  <= cause_i[CA_BD];
                    end else begin
                        exc_epc_o <= epc_calc;
                        exc_bd_o  <= mem_bd_i;
                    end
                    if ((code == EXC_ADEL) || (code == EXC_ADES)) begin
                        badv_we_o      <= 1'b1;
                        exc_badvaddr_o <= except_i[EF_ADEL_F] ? mem_pc_i : mem_addr_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int_i;
    logic        mem_valid_i;
    logic        stall_i;
    logic [31:0] mem_pc_i;
    logic        mem_bd_i;
    logic [7:0]  except_i;
    logic        adel_i;
    logic        ades_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [5:0]  hw_pending_o;
    logic        exc_valid_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic        exc_bd_o;
    logic [31:0] exc_badvaddr_o;
    logic        badv_we_o;
    logic        eret_o;
    logic        flush_o;
    logic [31:0] newpc_o;

    int checks   = 0;
    int failures = 0;

    exception_ctrl #(
        .NUM_HW_INT   (6),
        .SYNC_STAGES  (2),
        .FLUSH_CYCLES (3),
        .ADDR_W       (32),
        .EXC_VECTOR   (32'hBFC00380)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hw_int_i       (hw_int_i),
        .mem_valid_i    (mem_valid_i),
        .stall_i        (stall_i),
        .mem_pc_i       (mem_pc_i),
        .mem_bd_i       (mem_bd_i),
        .except_i       (except_i),
        .adel_i         (adel_i),
        .ades_i         (ades_i),
        .mem_addr_i     (mem_addr_i),
        .status_i       (status_i),
        .cause_i        (cause_i),
        .epc_i          (epc_i),
        .hw_pending_o   (hw_pending_o),
        .exc_valid_o    (exc_valid_o),
        .exc_code_o     (exc_code_o),
        .exc_epc_o      (exc_epc_o),
        .exc_bd_o       (exc_bd_o),
        .exc_badvaddr_o (exc_badvaddr_o),
        .badv_we_o      (badv_we_o),
        .eret_o         (eret_o),
        .flush_o        (flush_o),
        .newpc_o        (newpc_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hw_int_i    = '0;
        mem_valid_i = 1'b0;
        stall_i     = 1'b0;
        mem_pc_i    = '0;
        mem_bd_i    = 1'b0;
        except_i    = '0;
        adel_i      = 1'b0;
        ades_i      = 1'b0;
        mem_addr_i  = '0;
        status_i    = '0;
        cause_i     = '0;
        epc_i       = '0;
    endtask

    // Bounded wait for the flush window to close.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (flush_o === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check(tag, {31'b0, flush_o}, 32'h0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_exc_valid", {31'b0, exc_valid_o}, 32'h0);
        check("rst_flush",     {31'b0, flush_o},     32'h0);
        check("rst_eret",      {31'b0, eret_o},      32'h0);
        check("rst_newpc",     newpc_o,              32'h0);
        check("rst_pending",   {26'b0, hw_pending_o}, 32'h0);
        rst = 1'b0;

        // Hardware interrupt 0 through the synchroniser.
        status_i    = 32'h0000FF01;
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80000100;
        hw_int_i    = 6'b000001;
        tick();
        check("int_pend_t1", {26'b0, hw_pending_o}, 32'h0);
        tick();
        check("int_pend_t2", {26'b0, hw_pending_o}, 32'h1);
        check("int_noexc_t2", {31'b0, exc_valid_o}, 32'h0);
        tick();
        hw_int_i = '0;
        check("int_valid", {31'b0, exc_valid_o}, 32'h1);
        check("int_code",  {27'b0, exc_code_o},  32'h0);
        check("int_flush", {31'b0, flush_o},     32'h1);
        check("int_newpc", newpc_o,              32'hBFC00380);
        check("int_epc",   exc_epc_o,            32'h80000100);
        tick();
        check("int_strobe_once", {31'b0, exc_valid_o}, 32'h0);
        check("int_flush_c2",    {31'b0, flush_o},     32'h1);
        tick();
        check("int_flush_c3",    {31'b0, flush_o},     32'h1);
        clear_inputs();
        tick();
        check("int_flush_end",   {31'b0, flush_o},     32'h0);
        check("int_newpc_held",  newpc_o,              32'hBFC00380);

        // Store address error in a delay slot.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80001004;
        mem_bd_i    = 1'b1;
        ades_i      = 1'b1;
        mem_addr_i  = 32'h80002002;
        tick();
        clear_inputs();
        check("ades_code",  {27'b0, exc_code_o},  32'h05);
        check("ades_epc",   exc_epc_o,            32'h80001000);
        check("ades_bd",    {31'b0, exc_bd_o},    32'h1);
        check("ades_bwe",   {31'b0, badv_we_o},   32'h1);
        check("ades_badv",  exc_badvaddr_o,       32'h80002002);
        wait_idle("ades_idle");

        // Fetch AdEL plus data AdEL plus RI: fetch PC wins.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80000402;
        mem_addr_i  = 32'h12345679;
        except_i    = 8'h88;
        adel_i      = 1'b1;
        tick();
        clear_inputs();
        check("adel_code", {27'b0, exc_code_o}, 32'h04);
        check("adel_badv", exc_badvaddr_o,      32'h80000402);
        check("adel_bwe",  {31'b0, badv_we_o},  32'h1);
        check("adel_bd",   {31'b0, exc_bd_o},   32'h0);
        wait_idle("adel_idle");

        // ERET.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80000500;
        except_i    = 8'h10;
        epc_i       = 32'hBFC00100;
        tick();
        clear_inputs();
        check("eret_strobe", {31'b0, eret_o},      32'h1);
        check("eret_novalid", {31'b0, exc_valid_o}, 32'h0);
        check("eret_newpc",  newpc_o,              32'hBFC00100);
        check("eret_flush",  {31'b0, flush_o},     32'h1);
        tick();
        check("eret_once",   {31'b0, eret_o},      32'h0);
        check("eret_hold",   newpc_o,              32'hBFC00100);
        wait_idle("eret_idle");

        // Syscall held off by stall, then a second event inside the flush.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80000600;
        except_i    = 8'h40;
        stall_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sys_stalled", {31'b0, exc_valid_o | flush_o}, 32'h0);
        end
        stall_i = 1'b0;
        tick();
        check("sys_valid", {31'b0, exc_valid_o}, 32'h1);
        check("sys_code",  {27'b0, exc_code_o},  32'h08);
        check("sys_flush1", {31'b0, flush_o},    32'h1);
        except_i = 8'h20;
        tick();
        check("sys_ign2",   {31'b0, exc_valid_o}, 32'h0);
        check("sys_flush2", {31'b0, flush_o},     32'h1);
        tick();
        check("sys_ign3",   {31'b0, exc_valid_o}, 32'h0);
        check("sys_flush3", {31'b0, flush_o},     32'h1);
        tick();
        clear_inputs();
        check("sys_flush_end", {31'b0, flush_o},     32'h0);
        check("sys_ign4",      {31'b0, exc_valid_o}, 32'h0);

        // Overflow in a delay slot at PC 0: EPC wraps.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h00000000;
        mem_bd_i    = 1'b1;
        except_i    = 8'h04;
        tick();
        clear_inputs();
        check("ov_code", {27'b0, exc_code_o}, 32'h0c);
        check("ov_epc",  exc_epc_o,           32'hFFFFFFFC);
        check("ov_bwe",  {31'b0, badv_we_o},  32'h0);
        wait_idle("ov_idle");

        // RI with EXL already set: EPC/BD keep current values; SW interrupt masked by EXL.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80000010;
        except_i    = 8'h08;
        status_i    = 32'h0000FF03;
        cause_i     = 32'h80000100;
        epc_i       = 32'h11112220;
        tick();
        clear_inputs();
        check("exl_valid", {31'b0, exc_valid_o}, 32'h1);
        check("exl_code",  {27'b0, exc_code_o},  32'h0a);
        check("exl_epc",   exc_epc_o,            32'h11112220);
        check("exl_bd",    {31'b0, exc_bd_o},    32'h1);
        wait_idle("exl_idle");

        // Software interrupt 0 with a pending break: interrupt wins.
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h80000700;
        except_i    = 8'h20;
        status_i    = 32'h00000101;
        cause_i     = 32'h00000100;
        tick();
        clear_inputs();
        check("swint_code",  {27'b0, exc_code_o},  32'h00);
        check("swint_valid", {31'b0, exc_valid_o}, 32'h1);
        wait_idle("swint_idle");

        // Invalid slot: no event.
        except_i = 8'h40;
        tick();
        check("invalid_ignored", {31'b0, exc_valid_o | flush_o}, 32'h0);
        clear_inputs();

        // Reset in the middle of a flush.
        mem_valid_i = 1'b1;
        except_i    = 8'h20;
        tick();
        clear_inputs();
        check("rstmid_pre", {31'b0, flush_o}, 32'h1);
        rst = 1'b1;
        tick();
        check("rstmid_flush", {31'b0, flush_o},     32'h0);
        check("rstmid_valid", {31'b0, exc_valid_o}, 32'h0);
        check("rstmid_code",  {27'b0, exc_code_o},  32'h0);
        rst = 1'b0;
        tick();
        check("rstmid_idle",  {31'b0, flush_o | eret_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Registered, parametrised exception controller in the MEM stage of the 5-stage MIPS pipeline.
- Detects and prioritises interrupt, address-error, syscall, break, reserved-instruction, overflow and ERET events.
- Owns a flush sequence with a programmable length, and produces the CP0 write bundle (code, EPC, BD, BadVAddr) plus the redirect PC.
- Synchronises raw hardware interrupt lines internally.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6); these map to Cause/Status bits [10+NUM_HW_INT-1:10].
- SYNC_STAGES, 2, flip-flop stages on each hw_int line (>=2).
- FLUSH_CYCLES, 1, cycles flush_o stays high per event (1..4).
- ADDR_W, 32, PC and address width.
- EXC_VECTOR, 32'hBFC00380, redirect target for all non-ERET events.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- hw_int_i, input, NUM_HW_INT, asynchronous raw interrupt lines.
- mem_valid_i, input, 1, MEM slot holds a real instruction.
- stall_i, input, 1, MEM stage stalled this cycle.
- mem_pc_i, input, ADDR_W, PC of the MEM instruction.
- mem_bd_i, input, 1, MEM instruction is in a delay slot.
- except_i, input, 8, pipeline flags: [7] fetch AdEL, [6] syscall, [5] break, [4] eret, [3] RI, [2] overflow; [1:0] unused.
- adel_i, input, 1, load address misaligned.
- ades_i, input, 1, store address misaligned.
- mem_addr_i, input, ADDR_W, data address.
- status_i, input, 32, CP0 Status.
- cause_i, input, 32, CP0 Cause (bits [9:8] are the software interrupts).
- epc_i, input, ADDR_W, current CP0 EPC (ERET target).
- hw_pending_o, output, NUM_HW_INT, synchronised interrupt lines, for Cause.IP.
- exc_valid_o, output, 1, one-cycle CP0 write strobe.
- exc_code_o, output, 5, ExcCode.
- exc_epc_o, output, ADDR_W, EPC value.
- exc_bd_o, output, 1, Cause.BD value.
- exc_badvaddr_o, output, ADDR_W, BadVAddr value.
- badv_we_o, output, 1, BadVAddr write enable.
- eret_o, output, 1, ERET strobe (CP0 clears EXL).
- flush_o, output, 1, flush IF..MEM.
- newpc_o, output, ADDR_W, redirect PC; valid while flush_o is high.

Behaviour:
- Reset (synchronous, rst=1): all outputs 0; sync chains cleared; FSM to IDLE; flush counter 0.
- Interrupt condition: int_req = |({cause_i[15:10+NUM_HW_INT], hw_pending_o, cause_i[9:8]} & status_i[15:8]) && !status_i[1] && status_i[0].
  - Bits above NUM_HW_INT are forced to 0.
  - Latency from a hw_int_i edge to hw_pending_o is SYNC_STAGES cycles.
- Priority, evaluated combinationally only when mem_valid_i=1:
  - Interrupt, code 0x00.
  - except_i[7] or adel_i, code 0x04.
  - ades_i, code 0x05.
  - except_i[6], code 0x08.
  - except_i[5], code 0x09.
  - except_i[3], code 0x0a.
  - except_i[2], code 0x0c.
  - except_i[4], ERET.
- Detection while mem_valid_i=0 or stall_i=1 is ignored. The event is retaken once the instruction advances.
- FSM states:
  - IDLE → FLUSH on an accepted event.
  - In FLUSH, a counter counts FLUSH_CYCLES-1 down to 0, then returns to IDLE.
  - Detections during FLUSH are ignored.
  - rst in FLUSH returns to IDLE immediately with flush_o=0.
- Register stage (cycle after acceptance): exactly one cycle of exc_valid_o=1 (exception) or eret_o=1 (ERET), never both.
  - flush_o=1 for FLUSH_CYCLES cycles starting that same cycle.
- exc_epc_o: mem_pc_i-4 if mem_bd_i=1, else mem_pc_i. Arithmetic is modulo 2^ADDR_W, so mem_pc_i=0 with BD gives all-ones minus 3.
- exc_bd_o = mem_bd_i.
- BadVAddr:
  - badv_we_o=1 only for code 0x04/0x05.
  - Value is mem_pc_i for fetch AdEL (except_i[7]), otherwise mem_addr_i.
  - A fetch and a data AdEL together select mem_pc_i.
- Redirect: newpc_o = epc_i for ERET, otherwise EXC_VECTOR. It is held for the whole flush.
- EXL already 1 (status_i[1]) on a non-interrupt exception:
  - Still flush and write exc_code_o.
  - Drive exc_epc_o and exc_bd_o unchanged-indicator: exc_valid_o high but epc_keep asserted internally, so EPC and BD outputs equal epc_i and cause_i[31].
- Outputs other than flush_o and newpc_o return to 0 after their strobe cycle.

Decomposition:
- Shared package cp0_defs_pkg:
  - ExcCode localparams (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - Status/Cause bit-index constants.
  - FSM state enum.
- Sub-module int_sync, parametrised by WIDTH and STAGES; one instance for hw_int_i.

Test Plan:
- Status=0x0000FF01, a hw_int_i[0] pulse held for 3 cycles, mem_valid_i=1 → hw_pending_o[0] after 2 cycles; next cycle exc_valid_o=1, code 0x00, flush_o=1, newpc_o=0xBFC00380.
- mem_pc_i=0x80001004, mem_bd_i=1, ades_i=1, mem_addr_i=0x80002002 → code 0x05, exc_epc_o=0x80001000, exc_bd_o=1, badv_we_o=1, badvaddr 0x80002002.
- except_i=0x88 with adel_i=1 → code 0x04, badvaddr=mem_pc_i (fetch wins); RI is not reported.
- except_i[4]=1, epc_i=0xBFC00100 → eret_o=1, exc_valid_o=0, newpc_o=0xBFC00100.
- stall_i=1 with syscall for 3 cycles, then 0 → exactly one code 0x08 strobe, in the cycle after the stall drops. With FLUSH_CYCLES=3, flush_o is high for 3 cycles; a second event during that window is ignored.
- rst asserted in the middle of a flush → next cycle flush_o=0, FSM IDLE, all strobes 0.
